// File: rtl/pwm_sync_divider.sv
// pwm_sync_divider
//   Watches a PWM carrier for min/max events and emits a one-clock sync pulse
//   every (event_count+1) qualifying events. Divider ratio and event mode are
//   shadowed and only swap in at a period boundary (or while disabled).
//
// Parameters
//   CW : carrier / count_max width
//   EW : event divider width
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   ce           : carrier clock enable, events sampled only when high
//   count_max    : carrier peak value
//   carrier      : live carrier count
//   event_count  : requested divider N (sync every N+1 events), shadowed
//   sync_mode    : 0 every ce, 1 min, 2 max, 3 min or max, shadowed
//   sync_en      : divider enable
//   sync         : one-clock sync pulse (registered)
//   event_cnt    : current divider count
//   irq          : interrupt
//   irq_ack      : interrupt acknowledge
//   irq_ovf      : sticky overrun flag
//
// Configuration
//   PWM_SYNC_IRQ_LATCH_EN : when defined, irq is a sticky latch cleared by
//   irq_ack and irq_ovf flags a sync arriving while irq is still pending.
//   When undefined, irq mirrors sync and irq_ovf is tied low.
module pwm_sync_divider #(
  parameter int CW = 16,
  parameter int EW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [CW-1:0] count_max,
  input  logic [CW-1:0] carrier,
  input  logic [EW-1:0] event_count,
  input  logic [1:0]    sync_mode,
  input  logic          sync_en,
  output logic          sync,
  output logic [EW-1:0] event_cnt,
  output logic          irq,
  input  logic          irq_ack,
  output logic          irq_ovf
);

  logic [EW-1:0] act_count;
  logic [1:0]    act_mode;
  logic          is_min;
  logic          is_max;
  logic          mode_hit;
  logic          ev;
  logic          at_term;
  logic          term;

  // With count_max==0 both conditions are true at once; they are OR-ed into
  // a single event so one carrier sample never counts twice.
  always_comb begin
    is_min   = (carrier == '0);
    is_max   = (carrier == count_max);
    mode_hit = 1'b0;
    case (act_mode)
      2'd0:    mode_hit = 1'b1;
      2'd1:    mode_hit = is_min;
      2'd2:    mode_hit = is_max;
      default: mode_hit = is_min | is_max;
    endcase
    ev      = ce & mode_hit;
    at_term = (event_cnt == act_count);
    // Terminal event of the period: sync goes high on the next clock.
    term    = sync_en & ev & at_term;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 1'b0;
      event_cnt <= '0;
      act_count <= event_count;
      act_mode  <= sync_mode;
    end else begin
      sync <= term;
      if (!sync_en)
        event_cnt <= '0;
      else if (ev)
        event_cnt <= at_term ? '0 : event_cnt + 1'b1;
      // Shadow load at the period boundary so the next event already uses
      // the new settings; free-running load while the divider is off.
      if (!sync_en || term) begin
        act_count <= event_count;
        act_mode  <= sync_mode;
      end
    end
  end

`ifdef PWM_SYNC_IRQ_LATCH_EN
  // Set has priority over ack; overrun only when a new sync lands on a
  // pending, un-acked interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq     <= 1'b0;
      irq_ovf <= 1'b0;
    end else begin
      if (term)
        irq <= 1'b1;
      else if (irq_ack)
        irq <= 1'b0;
      if (term && irq && !irq_ack)
        irq_ovf <= 1'b1;
      else if (irq_ack)
        irq_ovf <= 1'b0;
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq            = sync;
  assign irq_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_sync_divider.sv
module tb_pwm_sync_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] count_max;
  logic [15:0] carrier;
  logic [3:0]  event_count;
  logic [1:0]  sync_mode;
  logic        sync_en;
  logic        sync;
  logic [3:0]  event_cnt;
  logic        irq;
  logic        irq_ack;
  logic        irq_ovf;

  int tests_run = 0;
  int failures  = 0;

  pwm_sync_divider #(.CW(16), .EW(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .count_max(count_max), .carrier(carrier),
    .event_count(event_count), .sync_mode(sync_mode), .sync_en(sync_en),
    .sync(sync), .event_cnt(event_cnt), .irq(irq), .irq_ack(irq_ack),
    .irq_ovf(irq_ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int tri_wave(int t, int m);
    int p;
    p = t % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  task automatic test_reset;
    count_max = 16'd10; carrier = 16'd0; ce = 1'b0; irq_ack = 1'b0;
    event_count = 4'd0; sync_mode = 2'd3; sync_en = 1'b1; rst = 1'b1;
    tick;
    tests_run++; if (sync !== 1'b0) begin failures++; $display("FAIL reset_sync got %b exp 0", sync); end
    tests_run++; if (event_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got %0d exp 0", event_cnt); end
    tests_run++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", irq); end
    tests_run++; if (irq_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b exp 0", irq_ovf); end
    rst = 1'b0;
  endtask

  // mode 3, N=0, triangle 0..10..0: sync after every min and max sample.
  task automatic test_triangle;
    int c;
    ce = 1'b1;
    for (int t = 0; t < 40; t++) begin
      c = tri_wave(t, 10);
      carrier = 16'(c);
      tick;
      tests_run++;
      if (sync !== ((c == 0) || (c == 10))) begin
        failures++; $display("FAIL tri_sync t=%0d carrier=%0d got %b exp %b", t, c, sync, (c == 0) || (c == 10));
      end
      tests_run++;
      if (event_cnt !== 4'd0) begin failures++; $display("FAIL tri_cnt t=%0d got %0d exp 0", t, event_cnt); end
    end
  endtask

  // mode 1, N=2, ce every 4th clock: one sync per three minima.
  task automatic test_decimate;
    int c;
    int exp_cnt;
    logic exp_sync;
    sync_en = 1'b0; ce = 1'b0; event_count = 4'd2; sync_mode = 2'd1;
    count_max = 16'd4; carrier = 16'd0;
    tick;
    sync_en = 1'b1;
    exp_cnt = 0;
    for (int t = 0; t < 56; t++) begin
      c = tri_wave(t, 4);
      carrier = 16'(c);
      for (int ph = 0; ph < 4; ph++) begin
        ce = (ph == 0);
        tick;
        exp_sync = 1'b0;
        if (ph == 0 && c == 0) begin
          if (exp_cnt == 2) begin exp_sync = 1'b1; exp_cnt = 0; end
          else exp_cnt++;
        end
        tests_run++;
        if (sync !== exp_sync) begin failures++; $display("FAIL dec_sync t=%0d ph=%0d got %b exp %b", t, ph, sync, exp_sync); end
        tests_run++;
        if (event_cnt !== 4'(exp_cnt)) begin failures++; $display("FAIL dec_cnt t=%0d ph=%0d got %0d exp %0d", t, ph, event_cnt, exp_cnt); end
      end
    end
    ce = 1'b0;
  endtask

  // N changes 3->1 mid-period: current period still ends at 3.
  task automatic test_shadow;
    int   exp_c[8] = '{1, 2, 3, 0, 1, 0, 1, 0};
    logic exp_s[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    sync_en = 1'b0; ce = 1'b0; event_count = 4'd3; sync_mode = 2'd0;
    tick;
    sync_en = 1'b1; ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0) event_count = 4'd1;
      tests_run++;
      if (sync !== exp_s[i]) begin failures++; $display("FAIL shadow_sync i=%0d got %b exp %b", i, sync, exp_s[i]); end
      tests_run++;
      if (event_cnt !== 4'(exp_c[i])) begin failures++; $display("FAIL shadow_cnt i=%0d got %0d exp %0d", i, event_cnt, exp_c[i]); end
    end
    ce = 1'b0;
  endtask

  // count_max=0 with mode 3: one event per ce tick, sync every second tick.
  task automatic test_zero_max;
    int   exp_c[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    logic exp_s[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    sync_en = 1'b0; ce = 1'b0; count_max = 16'd0; carrier = 16'd0;
    sync_mode = 2'd3; event_count = 4'd1;
    tick;
    sync_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0);
      tick;
      tests_run++;
      if (sync !== exp_s[i]) begin failures++; $display("FAIL zmax_sync i=%0d got %b exp %b", i, sync, exp_s[i]); end
      tests_run++;
      if (event_cnt !== 4'(exp_c[i])) begin failures++; $display("FAIL zmax_cnt i=%0d got %0d exp %0d", i, event_cnt, exp_c[i]); end
    end
    ce = 1'b0;
  endtask

  // Interrupt latch, ack, overrun and ack/set collision.
  task automatic test_irq;
    logic st_ce[8]  = '{1, 0, 1, 0, 1, 1, 0, 1};
    logic st_ack[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    logic exp_s[8]  = '{1, 0, 1, 0, 1, 1, 0, 1};
`ifdef PWM_SYNC_IRQ_LATCH_EN
    logic exp_i[8]  = '{1, 1, 1, 0, 1, 1, 1, 1};
    logic exp_o[8]  = '{0, 0, 1, 0, 0, 0, 0, 1};
`else
    logic exp_i[8]  = '{1, 0, 1, 0, 1, 1, 0, 1};
    logic exp_o[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    sync_en = 1'b0; ce = 1'b0; event_count = 4'd0; sync_mode = 2'd0; irq_ack = 1'b1;
    tick;
    sync_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ce = st_ce[i]; irq_ack = st_ack[i];
      tick;
      tests_run++;
      if (sync !== exp_s[i]) begin failures++; $display("FAIL irq_sync i=%0d got %b exp %b", i, sync, exp_s[i]); end
      tests_run++;
      if (irq !== exp_i[i]) begin failures++; $display("FAIL irq_flag i=%0d got %b exp %b", i, irq, exp_i[i]); end
      tests_run++;
      if (irq_ovf !== exp_o[i]) begin failures++; $display("FAIL irq_ovf i=%0d got %b exp %b", i, irq_ovf, exp_o[i]); end
    end
    ce = 1'b0; irq_ack = 1'b0;
  endtask

  // Reset mid-period, then a long disabled stretch, then re-enable.
  task automatic test_reset_disable;
    sync_en = 1'b0; ce = 1'b0; event_count = 4'd3; sync_mode = 2'd0;
    tick;
    sync_en = 1'b1; ce = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    tests_run++;
    if (event_cnt !== 4'd2) begin failures++; $display("FAIL mid_cnt got %0d exp 2", event_cnt); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests_run++; if (event_cnt !== 4'd0) begin failures++; $display("FAIL rst_cnt got %0d exp 0", event_cnt); end
    tests_run++; if (sync !== 1'b0) begin failures++; $display("FAIL rst_sync got %b exp 0", sync); end
    tests_run++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got %b exp 0", irq); end
    tick;
    tests_run++; if (event_cnt !== 4'd1) begin failures++; $display("FAIL post_rst_cnt got %0d exp 1", event_cnt); end
    sync_en = 1'b0; event_count = 4'd0;
    for (int i = 0; i < 100; i++) begin
      tick;
      tests_run++;
      if (sync !== 1'b0 || irq !== 1'b0) begin
        failures++; $display("FAIL dis_sync i=%0d got sync=%b irq=%b exp 0", i, sync, irq);
      end
      tests_run++;
      if (event_cnt !== 4'd0) begin failures++; $display("FAIL dis_cnt i=%0d got %0d exp 0", i, event_cnt); end
    end
    sync_en = 1'b1;
    tick;
    tests_run++;
    if (sync !== 1'b1) begin failures++; $display("FAIL reen_sync got %b exp 1", sync); end
    ce = 1'b0;
    tick;
    tests_run++;
    if (sync !== 1'b0) begin failures++; $display("FAIL reen_width got %b exp 0", sync); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; count_max = 16'd10; carrier = 16'd0;
    event_count = 4'd0; sync_mode = 2'd3; sync_en = 1'b1; irq_ack = 1'b0;
    test_reset;
    test_triangle;
    test_decimate;
    test_shadow;
    test_zero_max;
    test_irq;
    test_reset_disable;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
